// File: rtl/tt_slot_mux_wrapper.sv
// tt_slot_mux_wrapper
// Multiplexes one shared packed input bus (iw) and one shared packed output
// bus (ow) across N_PROJ user-project slots. A select handshake picks the
// active slot; a sequencer then disables the old slot for one cycle, holds
// the new slot in a forced project reset for RST_HOLD cycles, and finally
// lets it run.
//
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   sel_valid  slot-select request
//   sel_id     requested slot index
//   sel_ready  select accepted when sel_valid && sel_ready (IDLE or RUN)
//   iw         shared packed input {uio_in, ui_in, rst_n, clk}
//   ow         shared packed output {uio_oe, uio_out, uo_out}
//   proj_ena   per-slot enable, one-hot or zero
//   proj_iw    per-slot packed inputs, slot k at [k*IW_W +: IW_W]
//   proj_ow    per-slot packed outputs, slot k at [k*OW_W +: OW_W]
//   active_id  index of the currently driven slot
//   active     high while the selected slot is in RUN
module tt_slot_mux_wrapper #(
  parameter int N_PROJ   = 4,
  parameter int SEL_W    = 4,
  parameter int IW_W     = 18,
  parameter int OW_W     = 24,
  parameter int RST_HOLD = 4,
  parameter int OUT_REG  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sel_valid,
  input  logic [SEL_W-1:0]         sel_id,
  output logic                     sel_ready,
  input  logic [IW_W-1:0]          iw,
  output logic [OW_W-1:0]          ow,
  output logic [N_PROJ-1:0]        proj_ena,
  output logic [N_PROJ*IW_W-1:0]   proj_iw,
  input  logic [N_PROJ*OW_W-1:0]   proj_ow,
  output logic [SEL_W-1:0]         active_id,
  output logic                     active
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OFF,
    ST_HOLD,
    ST_RUN
  } state_t;

  localparam int CNT_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(RST_HOLD - 1);
  // One extra bit so N_PROJ = 2**SEL_W is still representable.
  localparam logic [SEL_W:0] N_PROJ_LIM = (SEL_W + 1)'(N_PROJ);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   active_id_q, active_id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               handshake;
  logic               sel_in_range;
  logic [OW_W-1:0]    ow_src;

  // New selects are only taken when no switch sequence is in flight.
  always_comb begin
    sel_ready    = (state_q == ST_IDLE) || (state_q == ST_RUN);
    handshake    = sel_valid && sel_ready;
    sel_in_range = ({1'b0, sel_id} < N_PROJ_LIM);
  end

  // Sequencer next-state. An out-of-range select drops to IDLE but keeps the
  // previous active_id; reselecting the current slot deliberately re-runs
  // the full OFF/HOLD sequence so it acts as a per-project soft reset.
  always_comb begin
    state_d     = state_q;
    active_id_d = active_id_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (handshake) begin
          if (sel_in_range) begin
            state_d     = ST_OFF;
            active_id_d = sel_id;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_OFF: begin
        state_d = ST_HOLD;
        cnt_d   = HOLD_LOAD;
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset abandons any switch in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      active_id_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      active_id_q <= active_id_d;
      cnt_q       <= cnt_d;
    end
  end

  // Slot routing. In HOLD the slot's rst_n field (bit1) is forced low while
  // its clk field (bit0) still passes through, so the project sees clocked
  // reset. The output source is only live in RUN.
  always_comb begin
    proj_ena = '0;
    proj_iw  = '0;
    ow_src   = '0;
    for (int k = 0; k < N_PROJ; k++) begin
      if (active_id_q == SEL_W'(k)) begin
        if ((state_q == ST_HOLD) || (state_q == ST_RUN)) begin
          proj_ena[k]              = 1'b1;
          proj_iw[k*IW_W +: IW_W]  = iw;
        end
        if (state_q == ST_HOLD) begin
          proj_iw[k*IW_W + 1] = 1'b0;
        end
        if (state_q == ST_RUN) begin
          ow_src = proj_ow[k*OW_W +: OW_W];
        end
      end
    end
  end

  // Optional output register: one cycle of latency, so the last RUN value
  // is still visible the first cycle after leaving RUN.
  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [OW_W-1:0] ow_q;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ow_q <= '0;
        end else begin
          ow_q <= ow_src;
        end
      end
      assign ow = ow_q;
    end else begin : g_out_comb
      assign ow = ow_src;
    end
  endgenerate

  assign active_id = active_id_q;
  assign active    = (state_q == ST_RUN);

endmodule

// File: tb/tb_tt_slot_mux_wrapper.sv
// tb_tt_slot_mux_wrapper
// Self-checking bench for tt_slot_mux_wrapper. The main instance uses the
// default build (4 slots, 4-cycle hold, registered ow). It is checked every
// cycle against a reference model that tracks "cycles elapsed since the last
// accepted select": 0 means the disable cycle, 1..RST_HOLD the forced-reset
// hold, anything later running. A second instance (1-cycle hold,
// combinational ow) gets a short directed sequence at the end.
module tb_tt_slot_mux_wrapper;

  localparam int N_PROJ   = 4;
  localparam int SEL_W    = 4;
  localparam int IW_W     = 18;
  localparam int OW_W     = 24;
  localparam int RST_HOLD = 4;

  logic                   clk;
  logic                   rst_n;
  logic                   sel_valid;
  logic [SEL_W-1:0]       sel_id;
  logic                   sel_ready;
  logic [IW_W-1:0]        iw;
  logic [OW_W-1:0]        ow;
  logic [N_PROJ-1:0]      proj_ena;
  logic [N_PROJ*IW_W-1:0] proj_iw;
  logic [N_PROJ*OW_W-1:0] proj_ow;
  logic [SEL_W-1:0]       active_id;
  logic                   active;

  logic                   rst_n2;
  logic                   sel_valid2;
  logic [SEL_W-1:0]       sel_id2;
  logic                   sel_ready2;
  logic [OW_W-1:0]        ow2;
  logic [N_PROJ-1:0]      proj_ena2;
  logic [N_PROJ*IW_W-1:0] proj_iw2;
  logic [SEL_W-1:0]       active_id2;
  logic                   active2;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int               m_since;
  int               m_slot;
  logic [OW_W-1:0]  m_ow;

  tt_slot_mux_wrapper #(
    .N_PROJ(N_PROJ), .SEL_W(SEL_W), .IW_W(IW_W), .OW_W(OW_W),
    .RST_HOLD(RST_HOLD), .OUT_REG(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sel_valid(sel_valid), .sel_id(sel_id),
    .sel_ready(sel_ready), .iw(iw), .ow(ow), .proj_ena(proj_ena),
    .proj_iw(proj_iw), .proj_ow(proj_ow), .active_id(active_id),
    .active(active)
  );

  tt_slot_mux_wrapper #(
    .N_PROJ(N_PROJ), .SEL_W(SEL_W), .IW_W(IW_W), .OW_W(OW_W),
    .RST_HOLD(1), .OUT_REG(0)
  ) dut2 (
    .clk(clk), .rst_n(rst_n2), .sel_valid(sel_valid2), .sel_id(sel_id2),
    .sel_ready(sel_ready2), .iw(iw), .ow(ow2), .proj_ena(proj_ena2),
    .proj_iw(proj_iw2), .proj_ow(proj_ow), .active_id(active_id2),
    .active(active2)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic expectEq(input string tag, input logic [95:0] obs,
                          input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_ready();
    return (m_since < 0) || (m_since > RST_HOLD);
  endfunction

  // Advance the model by one clock edge using the inputs present at it.
  task automatic modelEdge();
    logic [OW_W-1:0] src;
    src = (m_since > RST_HOLD) ? proj_ow[m_slot*OW_W +: OW_W] : '0;
    if (!rst_n) begin
      m_since = -1;
      m_slot  = 0;
      m_ow    = '0;
    end else begin
      m_ow = src;
      if (sel_valid && m_ready()) begin
        if (int'(sel_id) < N_PROJ) begin
          m_slot  = int'(sel_id);
          m_since = 0;
        end else begin
          m_since = -1;
        end
      end else if (m_since >= 0 && m_since <= RST_HOLD) begin
        m_since++;
      end
    end
  endtask

  // Compare every output of the main instance with the model.
  task automatic checkOutput();
    logic [N_PROJ-1:0]      exp_ena;
    logic [N_PROJ*IW_W-1:0] exp_iw;
    exp_ena = '0;
    exp_iw  = '0;
    if (m_since >= 1) begin
      exp_ena[m_slot] = 1'b1;
      exp_iw[m_slot*IW_W +: IW_W] = iw;
      if (m_since <= RST_HOLD) exp_iw[m_slot*IW_W + 1] = 1'b0;
    end
    expectEq("proj_ena", 96'(proj_ena), 96'(exp_ena));
    expectEq("proj_iw", 96'(proj_iw), 96'(exp_iw));
    expectEq("sel_ready", 96'(sel_ready), 96'(m_ready()));
    expectEq("active", 96'(active), 96'(m_since > RST_HOLD));
    expectEq("active_id", 96'(active_id), 96'(m_slot));
    expectEq("ow", 96'(ow), 96'(m_ow));
    expectEq("ena_onehot", 96'($countones(proj_ena) <= 1), 96'(1));
  endtask

  task automatic randomizeData();
    iw      = IW_W'($urandom) | IW_W'(2);
    proj_ow = {$urandom, $urandom, $urandom};
  endtask

  // One clock of the main instance: edge, model update, check, new data.
  task automatic applyStimulus();
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
    randomizeData();
  endtask

  // Handshake for slot id, then step until RUN, counting the disable cycles,
  // forced-reset cycles of that slot and not-ready cycles along the way.
  task automatic selectAndRun(input int id, output int off_n,
                              output int hold_n, output int busy_n);
    off_n  = 0;
    hold_n = 0;
    busy_n = 0;
    sel_valid = 1'b1;
    sel_id    = SEL_W'(id);
    applyStimulus();
    sel_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (active) break;
      if (!sel_ready) busy_n++;
      if (proj_ena == '0) off_n++;
      else if (proj_ena[id] && !proj_iw[id*IW_W + 1] && iw[1]) hold_n++;
      applyStimulus();
    end
    expectEq("reach_run", 96'(active), 96'(1));
  endtask

  initial begin
    int off_n, hold_n, busy_n;
    $display("[TB] start");
    rst_n      = 1'b0;
    sel_valid  = 1'b0;
    sel_id     = '0;
    rst_n2     = 1'b0;
    sel_valid2 = 1'b0;
    sel_id2    = '0;
    m_since    = -1;
    m_slot     = 0;
    m_ow       = '0;
    randomizeData();

    // Reset held two cycles, then idle.
    applyStimulus();
    applyStimulus();
    rst_n = 1'b1;
    applyStimulus();

    // First select: slot 2.
    selectAndRun(2, off_n, hold_n, busy_n);
    expectEq("sel2_off_cycles", 96'(off_n), 96'(1));
    expectEq("sel2_hold_cycles", 96'(hold_n), 96'(RST_HOLD));
    proj_ow[2*OW_W +: OW_W] = 24'hA5C3E1;
    applyStimulus();
    expectEq("sel2_ow_fixed", 96'(ow), 96'(24'hA5C3E1));
    applyStimulus();

    // Switch 2 -> 1 while running.
    selectAndRun(1, off_n, hold_n, busy_n);
    expectEq("sw1_busy_cycles", 96'(busy_n), 96'(RST_HOLD + 1));
    expectEq("sw1_off_cycles", 96'(off_n), 96'(1));
    applyStimulus();

    // Out-of-range select drops to idle but keeps active_id.
    sel_valid = 1'b1;
    sel_id    = 4'd7;
    applyStimulus();
    sel_valid = 1'b0;
    expectEq("inval_active_id", 96'(active_id), 96'(1));
    applyStimulus();
    applyStimulus();

    // Reselect the same slot gives a full soft reset.
    selectAndRun(1, off_n, hold_n, busy_n);
    selectAndRun(1, off_n, hold_n, busy_n);
    expectEq("resel_hold_cycles", 96'(hold_n), 96'(RST_HOLD));
    expectEq("resel_off_cycles", 96'(off_n), 96'(1));

    // Reset during the second hold cycle.
    sel_valid = 1'b1;
    sel_id    = 4'd3;
    applyStimulus();
    sel_valid = 1'b0;
    applyStimulus();
    applyStimulus();
    rst_n = 1'b0;
    applyStimulus();
    expectEq("midrst_ena", 96'(proj_ena), 96'(0));
    expectEq("midrst_ready", 96'(sel_ready), 96'(1));
    rst_n = 1'b1;
    applyStimulus();
    selectAndRun(0, off_n, hold_n, busy_n);
    expectEq("midrst_new_hold", 96'(hold_n), 96'(RST_HOLD));

    // Randomized traffic including rare resets and ignored requests.
    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(0, 39) != 0);
      sel_valid = ($urandom_range(0, 2) == 0);
      sel_id    = SEL_W'($urandom_range(0, 7));
      applyStimulus();
    end
    rst_n     = 1'b1;
    sel_valid = 1'b0;
    applyStimulus();

    // Second build: 1-cycle hold, combinational ow.
    @(posedge clk);
    #1;
    rst_n2 = 1'b1;
    @(posedge clk);
    #1;
    expectEq("b2_idle_ready", 96'(sel_ready2), 96'(1));
    sel_valid2 = 1'b1;
    sel_id2    = 4'd0;
    @(posedge clk);
    #1;
    expectEq("b2_off_ena", 96'(proj_ena2), 96'(0));
    expectEq("b2_off_ready", 96'(sel_ready2), 96'(0));
    sel_id2 = 4'd3;
    @(posedge clk);
    #1;
    sel_valid2 = 1'b0;
    expectEq("b2_hold_ena", 96'(proj_ena2), 96'(4'b0001));
    expectEq("b2_hold_rst", 96'(proj_iw2[1]), 96'(0));
    expectEq("b2_hold_active", 96'(active2), 96'(0));
    @(posedge clk);
    #1;
    expectEq("b2_run_active", 96'(active2), 96'(1));
    expectEq("b2_run_id", 96'(active_id2), 96'(0));
    expectEq("b2_run_ow", 96'(ow2), 96'(proj_ow[OW_W-1:0]));
    proj_ow[OW_W-1:0] = 24'h123456;
    #1;
    expectEq("b2_ow_comb", 96'(ow2), 96'(24'h123456));
    expectEq("b2_run_iw", 96'(proj_iw2[IW_W-1:0]), 96'(iw));
    @(posedge clk);
    #1;
    expectEq("b2_still_run", 96'(active2), 96'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
